fruit_slot_scheduler: RTL and testbench
=======================================

// Module: fruit_slot_scheduler
// PURPOSE
//  Owns the lifecycle of NUM_SLOTS fruit slots: placement, display, eaten and respawn.
//  Shares the one random-X source between slots with a round-robin req/valid handshake.
//  Clamps each X, latches the slot image at startOfFrame and runs per-slot respawn timers.
//  Sits between the LFSR random source, the collision unit and the fruit draw/mux logic.
// PARAMETERS
//  NUM_SLOTS       5    number of fruit slots (2..8)
//  RESPAWN_FRAMES  90   frames a slot stays empty after being eaten (1..255)
//  X_MIN           32   smallest legal fruit topLeftX
//  X_MAX           575  largest legal fruit topLeftX (X_MIN < X_MAX <= 639-32)
// PORTS
//  clk           in   1             system clock
//  resetN        in   1             asynchronous, active-low reset
//  startOfFrame  in   1             one-cycle pulse per video frame
//  enable        in   1             game running; low freezes timers and new requests
//  slotEaten     in   NUM_SLOTS     per-slot collision with the monkey (level or pulse)
//  rnd_valid     in   1             random source has a value on rnd_x
//  rnd_x         in   11            random X candidate (unsigned)
//  rnd_req       out  1             request for one random value
//  slotX         out  NUM_SLOTSx11  displayed topLeftX per slot
//  slotActive    out  NUM_SLOTS     displayed draw enable per slot
//  scoreInc      out  4             number of slots newly eaten this cycle (0 when idle)
//  allLoaded     out  1             every slot is internally ACTIVE
// BEHAVIOUR
//  Reset (async): all slots PENDING, timers 0, internal X 0, rr_ptr 0, fetch FSM IDLE.
//   Outputs at reset: rnd_req 0, slotX all 0, slotActive 0, scoreInc 0, allLoaded 0.
//  Per-slot states:
//   PENDING -> ACTIVE when the fetch FSM loads the slot.
//   ACTIVE -> COOLDOWN when slotEaten[i]=1; the timer loads RESPAWN_FRAMES.
//   COOLDOWN: timer decrements on startOfFrame only while enable=1.
//   COOLDOWN -> PENDING on the startOfFrame where the timer is 1.
//  slotEaten on a PENDING or COOLDOWN slot is ignored. A level input eats a slot once only.
//  scoreInc: registered popcount of ACTIVE->COOLDOWN transitions in that cycle.
//   Example: 2 slots eaten in one cycle -> scoreInc=2 for one cycle.
//  Fetch FSM, IDLE/REQ:
//   IDLE: if enable=1 and any slot is PENDING, select the first PENDING index at or
//    after rr_ptr (wrapping), latch it, go to REQ; rnd_req=1 from the next cycle.
//   REQ: rnd_req held at 1 until a cycle with rnd_valid=1 (rnd_x sampled only then).
//    On that cycle: X := rnd_x < X_MIN ? X_MIN : rnd_x > X_MAX ? X_MAX : rnd_x.
//    Same cycle: selected slot becomes ACTIVE; rr_ptr := (idx+1) mod NUM_SLOTS.
//    FSM returns to IDLE; rnd_req drops on the following cycle.
//   Throughput: at most one slot per 2 cycles; rnd_valid while rnd_req=0 is ignored.
//   enable falling during REQ: the transfer still completes; no new request starts after it.
//  Display image:
//   On startOfFrame, slotX/slotActive take the internal X and (state==ACTIVE).
//   The sample uses the state before that cycle's own updates (tear-free).
//   Eaten on a startOfFrame cycle: slot still drawn that frame, hidden from the next one.
//  allLoaded: registered AND of internal ACTIVE across all slots.
//  Mid-operation reset: request aborts at once; rnd_req=0 asynchronously.
// TESTING
//  1. Reset, enable=1, rnd_valid=1 with rnd_x=100,200,300,400,500 ->
//     slots load in order 0..4; allLoaded=1; next startOfFrame slotX={100..500}, slotActive=all 1.
//  2. rnd_x=5, then rnd_x=700 ->
//     loaded X=32 and X=575 (clamped); rnd_req drops one cycle after each accept.
//  3. slotEaten=5'b00101 for 3 cycles, RESPAWN_FRAMES=3 ->
//     scoreInc=2 for exactly 1 cycle; slots 0,2 hidden from next frame.
//     Slots 0,2 go PENDING on the 3rd startOfFrame; slot 0 refetched before slot 2 (rr_ptr).
//  4. Hold rnd_valid=0 for 50 cycles during REQ ->
//     rnd_req stays 1; no slot change; accepted on the first rnd_valid=1.
//  5. Slot in COOLDOWN, enable=0 for 10 frames ->
//     timer frozen; after enable=1, respawn takes the full remaining frame count.
//  6. Assert resetN low mid-REQ ->
//     all outputs return to reset values; loading restarts at slot 0 after release.

Source files
------------

// File: rtl/fruit_slot_scheduler.sv
// fruit_slot_scheduler
//   Owns the lifecycle of NUM_SLOTS fruit slots: placement, display, eaten and
//   respawn. Shares one random-X source between slots through a round-robin
//   req/valid handshake. Clamps each X, latches the displayed slot image on
//   startOfFrame and runs a per-slot respawn timer counted in frames.
//
// Ports
//   clk, resetN    system clock, asynchronous active-low reset
//   startOfFrame   one-cycle pulse per video frame
//   enable         game running; low freezes timers and new requests
//   slotEaten      per-slot collision with the monkey (level or pulse)
//   rnd_valid      random source has a value on rnd_x
//   rnd_x          random X candidate
//   rnd_req        request for one random value
//   slotX          displayed topLeftX per slot, slot i at [i*11 +: 11]
//   slotActive     displayed draw enable per slot
//   scoreInc       number of slots newly eaten in the previous cycle
//   allLoaded      every slot is internally ACTIVE
//
// Slot states
//   S_PENDING  | waiting for the fetch FSM to give it an X
//   S_ACTIVE   | placed and drawn; can be eaten
//   S_COOLDOWN | eaten; timer counts frames down to respawn
// Fetch states
//   F_IDLE     | looking for a pending slot (round-robin from rr_ptr)
//   F_REQ      | rnd_req high, waiting for rnd_valid for slot sel_idx
module fruit_slot_scheduler #(
  parameter int NUM_SLOTS      = 5,
  parameter int RESPAWN_FRAMES = 90,
  parameter int X_MIN          = 32,
  parameter int X_MAX          = 575
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     enable,
  input  logic [NUM_SLOTS-1:0]     slotEaten,
  input  logic                     rnd_valid,
  input  logic [10:0]              rnd_x,
  output logic                     rnd_req,
  output logic [NUM_SLOTS*11-1:0]  slotX,
  output logic [NUM_SLOTS-1:0]     slotActive,
  output logic [3:0]               scoreInc,
  output logic                     allLoaded
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [10:0]      XMIN_V   = 11'(X_MIN);
  localparam logic [10:0]      XMAX_V   = 11'(X_MAX);
  localparam logic [7:0]       RESP_V   = 8'(RESPAWN_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [IDX_W:0]   NUM_V    = (IDX_W+1)'(NUM_SLOTS);

  typedef enum logic [1:0] {
    S_PENDING  = 2'd0,
    S_ACTIVE   = 2'd1,
    S_COOLDOWN = 2'd2
  } slot_state_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fetch_state_t;

  slot_state_t      slot_st [NUM_SLOTS];
  logic [7:0]       timer   [NUM_SLOTS];
  logic [10:0]      x_int   [NUM_SLOTS];
  fetch_state_t     fetch_st;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_nxt;
  logic             sel_found;
  logic [IDX_W:0]   cand;
  logic [NUM_SLOTS-1:0] is_active;
  logic [NUM_SLOTS-1:0] is_pending;
  logic [NUM_SLOTS-1:0] eat_hit;
  logic [3:0]       eat_cnt;
  logic [10:0]      x_clamped;

  // Only ACTIVE slots can be eaten, so a held slotEaten level scores once.
  always_comb begin
    is_active  = '0;
    is_pending = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      is_active[i]  = (slot_st[i] == S_ACTIVE);
      is_pending[i] = (slot_st[i] == S_PENDING);
    end
    eat_hit = is_active & slotEaten;
    eat_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      eat_cnt = eat_cnt + 4'(eat_hit[i]);
    end
  end

  // First pending slot at or after rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_nxt   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NUM_V) cand = cand - NUM_V;
      if (!sel_found && is_pending[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_nxt   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    if (rnd_x < XMIN_V)      x_clamped = XMIN_V;
    else if (rnd_x > XMAX_V) x_clamped = XMAX_V;
    else                     x_clamped = rnd_x;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_st[i] <= S_PENDING;
        timer[i]   <= '0;
        x_int[i]   <= '0;
      end
      fetch_st   <= F_IDLE;
      rr_ptr     <= '0;
      sel_idx    <= '0;
      rnd_req    <= 1'b0;
      slotX      <= '0;
      slotActive <= '0;
      scoreInc   <= '0;
      allLoaded  <= 1'b0;
    end else begin
      scoreInc  <= eat_cnt;
      allLoaded <= &is_active;

      // Display image samples the pre-update state so a frame never tears.
      if (startOfFrame) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          slotX[i*11 +: 11] <= x_int[i];
        end
        slotActive <= is_active;
      end

      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (slot_st[i])
          S_ACTIVE: begin
            if (slotEaten[i]) begin
              slot_st[i] <= S_COOLDOWN;
              timer[i]   <= RESP_V;
            end
          end
          S_COOLDOWN: begin
            if (startOfFrame && enable) begin
              if (timer[i] == 8'd1) begin
                slot_st[i] <= S_PENDING;
                timer[i]   <= '0;
              end else begin
                timer[i] <= timer[i] - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end

      // The selected slot is PENDING, so the per-slot loop above never
      // writes it in the same cycle as the load below.
      case (fetch_st)
        F_IDLE: begin
          if (enable && sel_found) begin
            sel_idx  <= sel_nxt;
            fetch_st <= F_REQ;
            rnd_req  <= 1'b1;
          end
        end
        F_REQ: begin
          if (rnd_valid) begin
            x_int[sel_idx]   <= x_clamped;
            slot_st[sel_idx] <= S_ACTIVE;
            rr_ptr           <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
            fetch_st         <= F_IDLE;
            rnd_req          <= 1'b0;
          end
        end
        default: fetch_st <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_slot_scheduler.sv
// Testbench for fruit_slot_scheduler: table-driven load/clamp vectors,
// directed multi-cycle sequences and a randomized run, all checked every
// cycle against a slot-level reference model.
module tb_fruit_slot_scheduler;

  localparam int N    = 5;
  localparam int RESP = 3;
  localparam int XMIN = 32;
  localparam int XMAX = 575;

  logic            clk;
  logic            resetN;
  logic            startOfFrame;
  logic            enable;
  logic [N-1:0]    slotEaten;
  logic            rnd_valid;
  logic [10:0]     rnd_x;
  logic            rnd_req;
  logic [N*11-1:0] slotX;
  logic [N-1:0]    slotActive;
  logic [3:0]      scoreInc;
  logic            allLoaded;

  fruit_slot_scheduler #(
    .NUM_SLOTS(N), .RESPAWN_FRAMES(RESP), .X_MIN(XMIN), .X_MAX(XMAX)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .slotEaten(slotEaten), .rnd_valid(rnd_valid), .rnd_x(rnd_x),
    .rnd_req(rnd_req), .slotX(slotX), .slotActive(slotActive),
    .scoreInc(scoreInc), .allLoaded(allLoaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a slot is active, or waiting m_cd more frames, or
  // pending (inactive with nothing left to wait). m_busy is the slot whose
  // random value is being requested, -1 when no request is outstanding.
  bit          m_active [N];
  int          m_cd     [N];
  int          m_x      [N];
  int          m_disp_x [N];
  bit [N-1:0]  m_disp_act;
  int          m_rr, m_busy, m_score;
  bit          m_all;

  typedef struct {
    logic [10:0] rx;
    logic [10:0] exp_x;
  } load_vec_t;
  load_vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampx(input int v);
    if (v < XMIN) return XMIN;
    if (v > XMAX) return XMAX;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0; m_cd[i] = 0; m_x[i] = 0; m_disp_x[i] = 0;
    end
    m_disp_act = '0; m_rr = 0; m_busy = -1; m_score = 0; m_all = 0;
  endtask

  task automatic model_step();
    int hits, sel, j;
    bit all_act;
    bit [N-1:0] hit;
    if (!resetN) begin
      model_reset();
      return;
    end
    hits = 0; all_act = 1; sel = -1;
    for (int i = 0; i < N; i++) begin
      hit[i] = m_active[i] && slotEaten[i];
      hits += int'(hit[i]);
      if (!m_active[i]) all_act = 0;
    end
    if (startOfFrame)
      for (int i = 0; i < N; i++) begin
        m_disp_x[i]   = m_x[i];
        m_disp_act[i] = m_active[i];
      end
    if (m_busy < 0 && enable)
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (sel < 0 && !m_active[j] && m_cd[j] == 0) sel = j;
      end
    for (int i = 0; i < N; i++) begin
      if (hit[i]) begin
        m_active[i] = 0; m_cd[i] = RESP;
      end else if (!m_active[i] && m_cd[i] > 0 && startOfFrame && enable) begin
        m_cd[i]--;
      end
    end
    if (m_busy >= 0) begin
      if (rnd_valid) begin
        m_active[m_busy] = 1;
        m_x[m_busy]      = clampx(int'(rnd_x));
        m_rr             = (m_busy + 1) % N;
        m_busy           = -1;
      end
    end else begin
      m_busy = sel;
    end
    m_score = hits;
    m_all   = all_act;
  endtask

  task automatic compare_model();
    chk("rnd_req", int'(rnd_req), int'(m_busy >= 0));
    chk("slotActive", int'(slotActive), int'(m_disp_act));
    for (int i = 0; i < N; i++)
      chk($sformatf("slotX[%0d]", i), int'(slotX[i*11 +: 11]), m_disp_x[i]);
    chk("scoreInc", int'(scoreInc), m_score);
    chk("allLoaded", int'(allLoaded), int'(m_all));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic frame(input int gap);
    startOfFrame = 1'b1;
    cycle();
    startOfFrame = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; slotEaten = '0;
    rnd_valid = 1'b0; rnd_x = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_model();
    chk("reset_rnd_req", int'(rnd_req), 0);
    chk("reset_slotActive", int'(slotActive), 0);
    chk("reset_slotX", int'(|slotX), 0);
    resetN = 1'b1;
  endtask

  initial begin
    tbl[0] = '{11'd100, 11'd100}; tbl[1] = '{11'd200, 11'd200};
    tbl[2] = '{11'd300, 11'd300}; tbl[3] = '{11'd400, 11'd400};
    tbl[4] = '{11'd500, 11'd500};
    tbl[5] = '{11'd5,   11'd32};  tbl[6] = '{11'd700, 11'd575};
    tbl[7] = '{11'd31,  11'd32};  tbl[8] = '{11'd576, 11'd575};
    tbl[9] = '{11'd32,  11'd32};

    // In-order loading and X clamping, one group of five per reset.
    for (int g = 0; g < 2; g++) begin
      do_reset();
      enable = 1'b1; rnd_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        rnd_x = tbl[g*N + i].rx;
        cycle();
        chk("req_rise", int'(rnd_req), 1);
        cycle();
        chk("req_drop", int'(rnd_req), 0);
      end
      cycle();
      chk("allLoaded_set", int'(allLoaded), 1);
      frame(0);
      for (int i = 0; i < N; i++)
        chk($sformatf("load_x[%0d]", g*N + i), int'(slotX[i*11 +: 11]), int'(tbl[g*N + i].exp_x));
      chk("load_active", int'(slotActive), 5'h1f);
    end

    // Two slots eaten by a held level: scored once, hidden next frame,
    // respawned on the third frame with slot 0 refetched first.
    rnd_valid = 1'b0;
    slotEaten = 5'b00101;
    cycle(); chk("score_two", int'(scoreInc), 2);
    cycle(); chk("score_once", int'(scoreInc), 0);
    cycle(); chk("score_still0", int'(scoreInc), 0);
    slotEaten = '0;
    frame(2); chk("eaten_hidden", int'(slotActive), 5'b11010);
    frame(2); chk("no_early_req", int'(rnd_req), 0);
    frame(2); chk("respawn_req", int'(rnd_req), 1);
    rnd_valid = 1'b1; rnd_x = 11'd111;
    cycle();
    rnd_x = 11'd222;
    cycle(); cycle();
    rnd_valid = 1'b0;
    cycle();
    frame(1);
    chk("rr_first_x0", int'(slotX[0 +: 11]), 111);
    chk("rr_second_x2", int'(slotX[22 +: 11]), 222);
    chk("respawn_active", int'(slotActive), 5'h1f);

    // Long wait in REQ.
    slotEaten = 5'b00010;
    cycle();
    slotEaten = '0;
    frame(1); frame(1); frame(1);
    for (int c = 0; c < 50; c++) begin
      cycle();
      chk("req_hold", int'(rnd_req), 1);
    end
    rnd_valid = 1'b1; rnd_x = 11'd444;
    cycle();
    rnd_valid = 1'b0;
    chk("req_after_wait", int'(rnd_req), 0);
    frame(1);
    chk("wait_x1", int'(slotX[11 +: 11]), 444);

    // Cooldown frozen while disabled.
    slotEaten = 5'b01000;
    cycle();
    slotEaten = '0;
    frame(1);
    enable = 1'b0;
    repeat (10) frame(2);
    chk("frozen_hidden", int'(slotActive[3]), 0);
    chk("frozen_no_req", int'(rnd_req), 0);
    enable = 1'b1;
    frame(3); chk("resume_no_req", int'(rnd_req), 0);
    frame(1); chk("resume_req", int'(rnd_req), 1);

    // Reset in the middle of a request.
    #2 resetN = 1'b0;
    #1 chk("async_req_clear", int'(rnd_req), 0);
    chk("async_active_clear", int'(slotActive), 0);
    model_reset();
    cycle();
    resetN = 1'b1; enable = 1'b1; rnd_valid = 1'b1; rnd_x = 11'd77;
    cycle(); cycle();
    rnd_x = 11'd88;
    frame(0);
    chk("restart_active", int'(slotActive), 5'b00001);
    chk("restart_x0", int'(slotX[0 +: 11]), 77);

    // Randomized run.
    for (int c = 0; c < 3000; c++) begin
      resetN       = ($urandom_range(0, 499) != 0);
      startOfFrame = ($urandom_range(0, 7) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) slotEaten[i] = ($urandom_range(0, 11) == 0);
      rnd_valid    = $urandom_range(0, 1) != 0;
      rnd_x        = 11'($urandom_range(0, 2047));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
